// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and types for the VGA framebuffer scanout.
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_DEPTH    = FB_W * FB_H;
  localparam int ADDR_W      = 15;

  typedef enum logic {IDLE, CLEAR} wr_state_t;

  typedef logic [2:0] rgb_t;

  // y*160 + x built from shifts; the shift pair is specific to a 160-pixel row
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
    logic [ADDR_W-1:0] yw;
    yw = {{(ADDR_W-7){1'b0}}, y};
    return (yw << 7) + (yw << 5) + {{(ADDR_W-8){1'b0}}, x};
  endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Host-side pixel write and clear port of the framebuffer.
interface vga_fb_scanout_if;
  import vga_pkg::*;

  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  rgb_t       wr_rgb;
  logic       clr_req;
  rgb_t       clr_rgb;
  logic       clr_done;
  logic       wr_drop;

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, clr_req, clr_rgb,
    input  wr_ready, clr_done, wr_drop
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, clr_req, clr_rgb,
    output wr_ready, clr_done, wr_drop
  );

endinterface

// File: rtl/fb_dpram.sv
// Simple dual-port 3-bit RAM: write-only port A, read-only port B with registered output.
module fb_dpram import vga_pkg::*; #(
  parameter int DEPTH = FB_DEPTH,
  parameter int AW    = ADDR_W
) (
  input  logic          clock,
  input  logic          we_a_i,
  input  logic [AW-1:0] addr_a_i,
  input  rgb_t          din_a_i,
  input  logic          re_b_i,
  input  logic [AW-1:0] addr_b_i,
  output rgb_t          dout_b_o
);

  rgb_t mem_q [DEPTH];
  rgb_t dout_q;

  always_ff @(posedge clock) begin
    if (we_a_i) mem_q[addr_a_i] <= din_a_i;
  end

  // Read-before-write: a same-address collision returns the old word
  always_ff @(posedge clock) begin
    if (re_b_i) dout_q <= mem_q[addr_b_i];
  end

  assign dout_b_o = dout_q;

endmodule

// File: rtl/vga_fb_scanout.sv
// 160x120 framebuffer with host writes, a full-buffer clear engine and 4x4-replicated 640x480 scanout.
module vga_fb_scanout #(
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int ADDR_W      = vga_pkg::ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pix_en,
  input  logic [9:0]              hcount,
  input  logic [9:0]              vcount,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  vga_fb_scanout_if.slave         host,
  output logic                    red_F,
  output logic                    green_F,
  output logic                    blue_F,
  output logic                    hsync,
  output logic                    vsync
);
  import vga_pkg::*;

  localparam int LAST = FB_W * FB_H - 1;

  wr_state_t         state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  rgb_t              clr_rgb_q;
  logic              clr_done_q;
  logic              wr_drop_q;
  logic              wr_ready_q;

  logic              wr_fire;
  logic              wr_in_range;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  rgb_t              din_a;

  assign wr_fire     = (state_q == IDLE) && wr_ready_q && host.wr_valid;
  assign wr_in_range = (int'(host.wr_x) < FB_W) && (int'(host.wr_y) < FB_H);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_rgb_q  <= '0;
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      wr_ready_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          wr_ready_q <= 1'b1;
          if (wr_fire && !wr_in_range) wr_drop_q <= 1'b1;
          // A coincident write is still performed this clock; the clear begins on the next
          if (host.clr_req) begin
            clr_rgb_q  <= host.clr_rgb;
            clr_cnt_q  <= '0;
            state_q    <= CLEAR;
            wr_ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == ADDR_W'(LAST)) begin
            state_q    <= IDLE;
            clr_done_q <= 1'b1;
            wr_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    we_a   = 1'b0;
    addr_a = ADDR_W'(fb_addr(host.wr_y, host.wr_x));
    din_a  = host.wr_rgb;
    if (state_q == CLEAR) begin
      we_a   = 1'b1;
      addr_a = clr_cnt_q;
      din_a  = clr_rgb_q;
    end else if (wr_fire && wr_in_range) begin
      we_a = 1'b1;
    end
  end

  assign host.wr_ready = wr_ready_q;
  assign host.clr_done = clr_done_q;
  assign host.wr_drop  = wr_drop_q;

  logic              scan_active;
  logic              re_b;
  logic [ADDR_W-1:0] addr_b;
  rgb_t              rd_data;

  assign scan_active = (int'(hcount) < H_ACTIVE) && (int'(vcount) < V_ACTIVE);
  assign re_b        = pix_en && scan_active;
  assign addr_b      = ADDR_W'(fb_addr(vcount[SCALE_SHIFT+6:SCALE_SHIFT],
                                       hcount[SCALE_SHIFT+7:SCALE_SHIFT]));

  fb_dpram #(
    .DEPTH (FB_W * FB_H),
    .AW    (ADDR_W)
  ) u_ram (
    .clock    (clock),
    .we_a_i   (we_a),
    .addr_a_i (addr_a),
    .din_a_i  (din_a),
    .re_b_i   (re_b),
    .addr_b_i (addr_b),
    .dout_b_o (rd_data)
  );

  logic active_q;
  logic hs_q;
  logic vs_q;
  rgb_t rgb_out_q;
  logic hsync_q;
  logic vsync_q;

  // Stage 1 samples counters/syncs alongside the RAM read; stage 2 presents them one tick later
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active_q  <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_out_q <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else if (pix_en) begin
      active_q  <= scan_active;
      hs_q      <= hsync_in;
      vs_q      <= vsync_in;
      rgb_out_q <= active_q ? rd_data : 3'b000;
      hsync_q   <= hs_q;
      vsync_q   <= vs_q;
    end
  end

  assign {red_F, green_F, blue_F} = rgb_out_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
